// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and the bit-vote helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-FF synchroniser, tick-sampled history and majority vote
// over the three samples ending at the mid-bit strobe.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_tick,
  input  logic                          rx_in,
  input  logic [$clog2(OVERSAMPLE)-1:0] tick_cnt,
  output logic                          rx_sync,
  output logic                          vote,
  output logic                          mid_strobe
);

  localparam int CNT_W = $clog2(OVERSAMPLE);

  logic [1:0] sync_q;
  logic [1:0] hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      hist_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_in};
      if (sample_tick) hist_q <= {hist_q[0], rx_sync};
    end
  end

  // The current tick's sample joins the two held ones, so the vote is ready
  // on the tick with index OVERSAMPLE/2+1 (counter still shows OVERSAMPLE/2).
  always_comb begin
    rx_sync    = sync_q[1];
    vote       = majority3({hist_q, rx_sync});
    mid_strobe = sample_tick && (tick_cnt == CNT_W'(OVERSAMPLE / 2));
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: frame FSM, bit/tick counters, parity and stop
// checking, and a one-entry valid/ready output register with overrun pulse.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = 4;

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     tick_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_pend_q, frm_pend_q;
  logic                 rx_sync, vote, mid;
  logic                 start_det, last_data, last_stop, par_exp;
  logic                 complete, load;

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rx_in       (rx_in),
    .tick_cnt    (tick_cnt_q),
    .rx_sync     (rx_sync),
    .vote        (vote),
    .mid_strobe  (mid)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    complete  = 1'b0;
    start_det = (state_q == IDLE) && sample_tick && !rx_sync;
    last_data = (bit_cnt_q == BIT_W'(DATA_BITS - 1));
    last_stop = (bit_cnt_q == BIT_W'(STOP_BITS - 1));
    par_exp   = (PARITY_MODE == PARITY_ODD) ? ~^shift_q : ^shift_q;
    load      = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE:   if (start_det) state_d = START;
      START:  if (mid) state_d = vote ? IDLE : DATA;
      DATA:   if (mid && last_data) state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
      PARITY: if (mid) state_d = STOP;
      STOP: begin
        if (mid && last_stop) begin
          complete = 1'b1;
          state_d  = vote ? IDLE : BREAK;
        end
      end
      BREAK:  if (sample_tick && rx_sync) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    load = complete && (!dout_valid || dout_ready);
  end

  // Tick counter is held at 0 in IDLE so the start-detect tick is index 0;
  // votes, and therefore all state changes, then land once per bit period.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_pend_q <= 1'b0;
      frm_pend_q <= 1'b0;
    end else begin
      if (sample_tick) begin
        if (state_q == IDLE || tick_cnt_q == CNT_W'(OVERSAMPLE - 1)) tick_cnt_q <= '0;
        else tick_cnt_q <= tick_cnt_q + 1'b1;
      end
      if (state_d != state_q) bit_cnt_q <= '0;
      else if (mid && (state_q == DATA || state_q == STOP)) bit_cnt_q <= bit_cnt_q + 1'b1;
      if (mid && state_q == DATA) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
      if (start_det) begin
        par_pend_q <= 1'b0;
        frm_pend_q <= 1'b0;
      end else begin
        if (mid && state_q == PARITY) par_pend_q <= (vote != par_exp);
        if (mid && state_q == STOP && !vote) frm_pend_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout        <= '0;
      dout_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= complete && !load;
      if (load) begin
        dout       <= shift_q;
        dout_valid <= 1'b1;
        parity_err <= par_pend_q;
        frame_err  <= frm_pend_q | ~vote;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: three instances (8E1, 8O1, 8N2) each on its
// own serial line, frames built bit-by-bit and checked against a frame model.
module tb_uart_rx_oversampled;

  localparam int OS  = 16;
  localparam int BIT = OS * 4;

  typedef struct packed {
    logic [1:0] dut;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_tick = 1'b0;
  logic [1:0] tick_div = 2'd0;
  logic [2:0] rx_line = 3'b111;
  logic [2:0] ready = 3'b111;

  logic [7:0] dout_a [3];
  logic [2:0] valid_a, perr_a, ferr_a, ovr_a, busy_a;

  int tests = 0;
  int fails = 0;
  int vcnt [3];
  int ocnt [3];
  ent_t mq[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_div    <= tick_div + 2'd1;
    sample_tick <= (tick_div == 2'd3);
  end

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(1), .STOP_BITS(1)) dut_e (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx_in(rx_line[0]),
    .dout(dout_a[0]), .dout_valid(valid_a[0]), .dout_ready(ready[0]),
    .parity_err(perr_a[0]), .frame_err(ferr_a[0]), .overrun_err(ovr_a[0]), .busy(busy_a[0]));

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(2), .STOP_BITS(1)) dut_o (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx_in(rx_line[1]),
    .dout(dout_a[1]), .dout_valid(valid_a[1]), .dout_ready(ready[1]),
    .parity_err(perr_a[1]), .frame_err(ferr_a[1]), .overrun_err(ovr_a[1]), .busy(busy_a[1]));

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(0), .STOP_BITS(2)) dut_n (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx_in(rx_line[2]),
    .dout(dout_a[2]), .dout_valid(valid_a[2]), .dout_ready(ready[2]),
    .parity_err(perr_a[2]), .frame_err(ferr_a[2]), .overrun_err(ovr_a[2]), .busy(busy_a[2]));

  // Records every accepted word plus valid/overrun high-cycle counts.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (valid_a[i]) vcnt[i]++;
      if (ovr_a[i]) ocnt[i]++;
      if (valid_a[i] && ready[i] && !reset)
        mq.push_back('{dut: 2'(i), data: dout_a[i], perr: perr_a[i], ferr: ferr_a[i]});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic even_bit(input logic [7:0] d);
    return logic'($countones(d) % 2);
  endfunction

  // Reference: parity bit that a correct transmitter would send for this mode.
  function automatic logic want_parity(input int pmode, input logic [7:0] d);
    return (pmode == 2) ? !even_bit(d) : even_bit(d);
  endfunction

  task automatic send_frame(input int d, input logic [7:0] data, input int pmode,
                            input logic pbit, input int nstop, input logic [1:0] stops);
    rx_line[d] = 1'b0;
    step(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_line[d] = data[i];
      step(BIT);
    end
    if (pmode != 0) begin
      rx_line[d] = pbit;
      step(BIT);
    end
    for (int i = 0; i < nstop; i++) begin
      rx_line[d] = stops[i];
      step(BIT);
    end
  endtask

  task automatic check_entry(input string nm, input int d, input logic [7:0] data,
                             input logic perr, input logic ferr);
    ent_t e;
    tests++;
    if (mq.size() != 1) begin
      fails++;
      $display("FAIL %s count: got %0d words, want 1", nm, mq.size());
      mq.delete();
      return;
    end
    e = mq.pop_front();
    tests++;
    if (e.dut !== 2'(d) || e.data !== data) begin
      fails++;
      $display("FAIL %s data: got dut%0d 0x%02h, want dut%0d 0x%02h", nm, e.dut, e.data, d, data);
    end
    tests++;
    if (e.perr !== perr || e.ferr !== ferr) begin
      fails++;
      $display("FAIL %s flags: got perr=%b ferr=%b, want perr=%b ferr=%b", nm, e.perr, e.ferr, perr, ferr);
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({dout_a[i], valid_a[i], perr_a[i], ferr_a[i], ovr_a[i], busy_a[i]} !== 13'd0) begin
        fails++;
        $display("FAIL %s dut%0d: got dout=%02h v=%b p=%b f=%b o=%b b=%b, want all 0", nm, i,
                 dout_a[i], valid_a[i], perr_a[i], ferr_a[i], ovr_a[i], busy_a[i]);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(4);
    check_idle_outputs("reset");
    reset = 1'b0;
    step(8);
    check_idle_outputs("post_reset");
  endtask

  task automatic test_even;
    int v0;
    mq.delete();
    v0 = vcnt[0];
    send_frame(0, 8'hA5, 1, 1'b0, 1, 2'b11);
    step(16);
    check_entry("even_a5", 0, 8'hA5, 1'b0 != want_parity(1, 8'hA5), 1'b0);
    tests++;
    if (vcnt[0] - v0 != 1) begin
      fails++;
      $display("FAIL even_valid_width: got %0d cycles, want 1", vcnt[0] - v0);
    end
  endtask

  task automatic test_odd;
    mq.delete();
    send_frame(1, 8'h3C, 2, 1'b0, 1, 2'b11);
    step(16);
    check_entry("odd_3c", 1, 8'h3C, 1'b0 != want_parity(2, 8'h3C), 1'b0);
  endtask

  task automatic test_break;
    mq.delete();
    send_frame(2, 8'h81, 0, 1'b0, 2, 2'b01);
    rx_line[2] = 1'b0;
    step(20 * BIT);
    tests++;
    if (busy_a[2] !== 1'b1) begin
      fails++;
      $display("FAIL break_busy: got %b, want 1", busy_a[2]);
    end
    check_entry("break_frame", 2, 8'h81, 1'b0, 1'b1);
    rx_line[2] = 1'b1;
    step(16);
    tests++;
    if (busy_a[2] !== 1'b0) begin
      fails++;
      $display("FAIL break_exit: got busy=%b, want 0", busy_a[2]);
    end
  endtask

  task automatic test_false_start;
    int v0;
    mq.delete();
    v0 = vcnt[0];
    rx_line[0] = 1'b0;
    step(16);
    tests++;
    if (busy_a[0] !== 1'b1) begin
      fails++;
      $display("FAIL false_start_busy: got %b, want 1", busy_a[0]);
    end
    rx_line[0] = 1'b1;
    step(2 * BIT);
    tests++;
    if (busy_a[0] !== 1'b0 || vcnt[0] != v0) begin
      fails++;
      $display("FAIL false_start_idle: got busy=%b valid_cycles=%0d, want busy=0 valid_cycles=0",
               busy_a[0], vcnt[0] - v0);
    end
  endtask

  task automatic test_back_to_back;
    int o0;
    mq.delete();
    o0 = ocnt[0];
    ready[0] = 1'b0;
    send_frame(0, 8'h11, 1, want_parity(1, 8'h11), 1, 2'b11);
    send_frame(0, 8'h22, 1, want_parity(1, 8'h22), 1, 2'b11);
    step(16);
    tests++;
    if (valid_a[0] !== 1'b1 || dout_a[0] !== 8'h11) begin
      fails++;
      $display("FAIL b2b_hold: got valid=%b dout=0x%02h, want valid=1 dout=0x11", valid_a[0], dout_a[0]);
    end
    tests++;
    if (ocnt[0] - o0 != 1) begin
      fails++;
      $display("FAIL b2b_overrun: got %0d pulse cycles, want 1", ocnt[0] - o0);
    end
    ready[0] = 1'b1;
    step(1);
    tests++;
    if (valid_a[0] !== 1'b0) begin
      fails++;
      $display("FAIL b2b_accept: got valid=%b, want 0", valid_a[0]);
    end
    check_entry("b2b_word", 0, 8'h11, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    mq.delete();
    ready[0] = 1'b0;
    send_frame(0, 8'h33, 1, want_parity(1, 8'h33), 1, 2'b11);
    d = 8'hC6;
    rx_line[0] = 1'b0;
    step(BIT);
    for (int i = 0; i < 3; i++) begin
      rx_line[0] = d[i];
      step(BIT);
    end
    rx_line[0] = d[3];
    step(BIT / 2);
    reset = 1'b1;
    rx_line[0] = 1'b1;
    step(1);
    reset = 1'b0;
    check_idle_outputs("reset_mid");
    ready[0] = 1'b1;
    step(2 * BIT);
    send_frame(0, 8'h5A, 1, want_parity(1, 8'h5A), 1, 2'b11);
    step(16);
    check_entry("after_reset_5a", 0, 8'h5A, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 12; n++) begin
      int d, pm;
      logic [7:0] data;
      logic pbit, stp;
      d    = int'($urandom_range(0, 1));
      pm   = (d == 0) ? 1 : 2;
      data = 8'($urandom);
      pbit = want_parity(pm, data) ^ ($urandom_range(0, 3) == 0);
      stp  = ($urandom_range(0, 3) != 0);
      mq.delete();
      send_frame(d, data, pm, pbit, 1, {1'b1, stp});
      rx_line[d] = 1'b1;
      step(16);
      check_entry("random", d, data, pbit != want_parity(pm, data), !stp);
      step(int'($urandom_range(0, 1)) * BIT + (stp ? 0 : BIT));
    end
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_break();
    test_false_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
